// File: rtl/trie_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trie_pkg
// Description : Shared widths, opcodes, FSM states and helper functions for
//               the trie stage RAM write side.
// Revision    : 1.0 - initial release
// ============================================================================
package trie_pkg;

    localparam int STRIDE_W = 4;   // stride bits per trie stage
    localparam int ENTRY_W  = 9;   // stage RAM word {exist, nexthop}
    localparam int LEN_W    = 3;   // prefix length within a stride, 0..4
    localparam int NH_W     = 8;   // next-hop width
    localparam int CNT_W    = 5;   // written-entry count, 0..16

    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_DELETE = 1'b1;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        CHECK  = 3'd2,
        EXPAND = 3'd3,
        FIN    = 3'd4
    } state_t;

    // Per-entry record of which prefix length currently owns the entry
    typedef struct packed {
        logic             valid;
        logic [LEN_W-1:0] len;
    } shadow_t;

    // Number of 16-entry block slots covered by a prefix of this length
    function automatic logic [CNT_W-1:0] expand_count(input logic [LEN_W-1:0] len);
        return CNT_W'(1) << (3'd4 - len);
    endfunction

    // Keeps the significant (top len) stride bits, clears the rest
    function automatic logic [STRIDE_W-1:0] stride_mask(input logic [LEN_W-1:0] len);
        return {STRIDE_W{1'b1}} << (3'd4 - len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shadow_len_ram.sv
`default_nettype none
// ============================================================================
// Module      : shadow_len_ram
// Description : Shadow array of {valid, prefix length} per stage RAM entry.
//               Asynchronous read, synchronous write. Out-of-range addresses
//               read as empty and are never written.
// Revision    : 1.0 - initial release
// ============================================================================
module shadow_len_ram
    import trie_pkg::*;
#(
    parameter int NUM_ENTRY = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  shadow_t           wdata,
    input  logic [ADDR_W-1:0] raddr,
    output shadow_t           rdata
);

    localparam int                IDX_W = $clog2(NUM_ENTRY);
    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(NUM_ENTRY);

    shadow_t mem [NUM_ENTRY];

    logic rd_ok;
    logic wr_ok;

    assign rd_ok = ({1'b0, raddr} < LIMIT);
    assign wr_ok = ({1'b0, waddr} < LIMIT);

    assign rdata = rd_ok ? mem[raddr[IDX_W-1:0]] : '0;

    // Storage update; contents are initialised by the writer's reset sweep
    always_ff @(posedge clk) begin
        if (we && wr_ok) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stage_ram_writer.sv
`default_nettype none
// ============================================================================
// Module      : stage_ram_writer
// Description : Write side of one 4-bit-stride trie stage RAM. Sweeps the RAM
//               to zero after reset, then serves insert/delete requests by
//               expanding a 0..4-bit sub-prefix over its 16-entry block,
//               honouring longest-prefix ownership via a shadow length array.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_ram_writer
    import trie_pkg::*;
#(
    parameter int NUM_ENTRY      = 1024,
    parameter int RAM_DATA_WIDTH = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_op,
    input  logic [RAM_DATA_WIDTH-1:0]   req_ram_index,
    input  logic [STRIDE_W-1:0]         req_stride,
    input  logic [LEN_W-1:0]            req_len,
    input  logic [NH_W-1:0]             req_nexthop,
    output logic                        wr_en,
    output logic [RAM_DATA_WIDTH+3:0]   wr_addr,
    output logic [ENTRY_W-1:0]          wr_data,
    output logic                        done,
    output logic [CNT_W-1:0]            done_count,
    output logic                        err,
    output logic                        init_busy
);

    localparam int              ADDR_W      = RAM_DATA_WIDTH + STRIDE_W;
    localparam logic [ADDR_W:0] ENTRY_LIMIT = (ADDR_W+1)'(NUM_ENTRY);

    state_t state;
    state_t state_next;

    // Sweep pointer runs one past the last entry so the final write is seen
    // on the bus while init_busy is still high.
    logic [ADDR_W:0]            init_addr;

    // Latched request
    logic                       op_q;
    logic [RAM_DATA_WIDTH-1:0]  idx_q;
    logic [STRIDE_W-1:0]        stride_q;
    logic [LEN_W-1:0]           len_q;
    logic [NH_W-1:0]            nh_q;

    // Expansion progress
    logic [CNT_W-1:0]           k;
    logic [CNT_W-1:0]           cnt;

    // Derived request quantities
    logic [CNT_W-1:0]           n_total;
    logic [STRIDE_W-1:0]        base;
    logic [STRIDE_W-1:0]        cand_stride;
    logic [ADDR_W-1:0]          cand_addr;
    logic                       k_live;
    logic                       req_err;
    logic                       hit;

    // Write issue for the next cycle (stage RAM and shadow in lockstep)
    logic                       issue;
    logic [ADDR_W-1:0]          issue_addr;
    logic [ENTRY_W-1:0]         issue_data;
    shadow_t                    sh_wdata;
    shadow_t                    sh_rdata;

    assign n_total     = expand_count(len_q);
    assign base        = stride_q & stride_mask(len_q);
    assign cand_stride = base | k[STRIDE_W-1:0];
    assign cand_addr   = {idx_q, cand_stride};
    assign k_live      = (k != n_total);

    // A block index past the end of the RAM, an oversize length, or an insert
    // of next hop 0 (which the lookup side reads as "absent") is rejected.
    assign req_err = (len_q > 3'd4)
                  || ((op_q == OP_INSERT) && (nh_q == '0))
                  || ({1'b0, idx_q, {STRIDE_W{1'b0}}} >= ENTRY_LIMIT);

    // Insert claims entries owned by an equal-or-shorter prefix; delete only
    // clears entries owned by exactly this prefix length.
    assign hit = (op_q == OP_INSERT) ? (!sh_rdata.valid || (sh_rdata.len <= len_q))
                                     : (sh_rdata.valid && (sh_rdata.len == len_q));

    assign req_ready = (state == IDLE);
    assign init_busy = (state == INIT);

    shadow_len_ram #(
        .NUM_ENTRY (NUM_ENTRY),
        .ADDR_W    (ADDR_W)
    ) u_shadow (
        .clk   (clk),
        .we    (issue),
        .waddr (issue_addr),
        .wdata (sh_wdata),
        .raddr (cand_addr),
        .rdata (sh_rdata)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and write-issue decode
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        issue_addr = '0;
        issue_data = '0;
        sh_wdata   = '0;
        case (state)
            INIT: begin
                if (init_addr == ENTRY_LIMIT) begin
                    state_next = IDLE;
                end else begin
                    issue      = 1'b1;
                    issue_addr = init_addr[ADDR_W-1:0];
                end
            end
            IDLE: begin
                if (req_valid) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = req_err ? FIN : EXPAND;
            end
            EXPAND: begin
                if (!k_live) begin
                    state_next = FIN;
                end else if (hit) begin
                    issue      = 1'b1;
                    issue_addr = cand_addr;
                    if (op_q == OP_INSERT) begin
                        issue_data = {1'b1, nh_q};
                        sh_wdata   = '{valid: 1'b1, len: len_q};
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // Request latch, sweep pointer and expansion counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_addr <= '0;
            op_q      <= OP_INSERT;
            idx_q     <= '0;
            stride_q  <= '0;
            len_q     <= '0;
            nh_q      <= '0;
            k         <= '0;
            cnt       <= '0;
        end else begin
            if ((state == INIT) && (init_addr != ENTRY_LIMIT)) begin
                init_addr <= init_addr + 1'b1;
            end
            if ((state == IDLE) && req_valid) begin
                op_q     <= req_op;
                idx_q    <= req_ram_index;
                stride_q <= req_stride;
                len_q    <= req_len;
                nh_q     <= req_nexthop;
                cnt      <= '0;
            end
            if (state == CHECK) begin
                k <= '0;
            end
            if ((state == EXPAND) && k_live) begin
                k <= k + 1'b1;
                if (hit) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Registered write port and completion outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            done_count <= '0;
        end else begin
            wr_en      <= issue;
            wr_addr    <= issue_addr;
            wr_data    <= issue_data;
            done       <= 1'b0;
            err        <= 1'b0;
            done_count <= '0;
            if ((state == CHECK) && req_err) begin
                done <= 1'b1;
                err  <= 1'b1;
            end
            if ((state == EXPAND) && !k_live) begin
                done       <= 1'b1;
                done_count <= cnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_ram_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_ram_writer
// Description : Directed self-checking bench for stage_ram_writer with a
//               32-entry RAM (two 16-entry blocks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_ram_writer;

    localparam int NUM_ENTRY      = 32;
    localparam int RAM_DATA_WIDTH = 6;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [5:0]  req_ram_index;
    logic [3:0]  req_stride;
    logic [2:0]  req_len;
    logic [7:0]  req_nexthop;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [8:0]  wr_data;
    logic        done;
    logic [4:0]  done_count;
    logic        err;
    logic        init_busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int done_seen = 0;

    logic [9:0] wl_addr[$];
    logic [8:0] wl_data[$];
    int         wl_cyc[$];
    logic [8:0] ram [0:31];

    stage_ram_writer #(
        .NUM_ENTRY      (NUM_ENTRY),
        .RAM_DATA_WIDTH (RAM_DATA_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_ram_index (req_ram_index),
        .req_stride    (req_stride),
        .req_len       (req_len),
        .req_nexthop   (req_nexthop),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .done          (done),
        .done_count    (done_count),
        .err           (err),
        .init_busy     (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the write port and done pulses away from the active edge
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wl_addr.push_back(wr_addr);
            wl_data.push_back(wr_data);
            wl_cyc.push_back(cyc);
            if (wr_addr < 10'd32) ram[wr_addr[4:0]] = wr_data;
        end
        if (done === 1'b1) done_seen++;
    end

    task automatic clear_log();
        wl_addr.delete();
        wl_data.delete();
        wl_cyc.delete();
    endtask

    // Issue one request and wait (bounded) for its done pulse
    task automatic do_req(input logic op, input logic [5:0] idx, input logic [3:0] stride,
                          input logic [2:0] len, input logic [7:0] nh,
                          output int t_acc, output int t_done,
                          output logic [4:0] cnt, output logic e);
        int guard;
        t_done = -1;
        cnt    = 5'h1F;
        e      = 1'bx;
        guard  = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        clear_log();
        req_op        = op;
        req_ram_index = idx;
        req_stride    = stride;
        req_len       = len;
        req_nexthop   = nh;
        req_valid     = 1'b1;
        t_acc         = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                t_done = cyc;
                cnt    = done_count;
                e      = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int guard;
        int bad;
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 1'b0;
        req_ram_index = '0;
        req_stride = '0;
        req_len = '0;
        req_nexthop = '0;
        #3;
        checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_init_busy: got %b expected 1", init_busy); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        checks++; if ({done, err, done_count} !== 7'd0) begin errors++; $display("FAIL reset_done_err_cnt: got %b/%b/%0d expected 0/0/0", done, err, done_count); end
        clear_log();
        @(negedge clk);
        rst = 1'b0;
        guard = 0;
        while (init_busy !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++; if (wl_addr.size() != 32) begin errors++; $display("FAIL sweep_count: got %0d expected 32", wl_addr.size()); end
        bad = 0;
        for (int i = 0; i < wl_addr.size(); i++) if (wl_addr[i] !== 10'(i) || wl_data[i] !== 9'h000) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL sweep_addr_data: got %0d bad writes expected 0", bad); end
        checks++; if (wl_cyc.size() == 0 || wl_cyc[wl_cyc.size()-1] != cyc - 1) begin errors++; $display("FAIL sweep_busy_fall: init_busy fell at cycle %0d, last write not in cycle before", cyc); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_insert_basic();
        int t, td;
        logic [4:0] c;
        logic e;
        do_req(1'b0, 6'd1, 4'b1010, 3'd2, 8'h05, t, td, c, e);
        checks++; if (wl_addr.size() != 4) begin errors++; $display("FAIL ins_write_count: got %0d expected 4", wl_addr.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= wl_addr.size()) begin
                errors++; $display("FAIL ins_write%0d: missing expected addr %0h", k, 24 + k);
            end else if (wl_addr[k] !== 10'(24 + k) || wl_data[k] !== 9'h105 || wl_cyc[k] != t + 3 + k) begin
                errors++; $display("FAIL ins_write%0d: got addr %0h data %0h cyc %0d expected %0h 105 %0d", k, wl_addr[k], wl_data[k], wl_cyc[k] - t, 24 + k, 3 + k);
            end
        end
        checks++; if (td != t + 7) begin errors++; $display("FAIL ins_done_time: got T+%0d expected T+7", td - t); end
        checks++; if (c !== 5'd4 || e !== 1'b0) begin errors++; $display("FAIL ins_count_err: got %0d/%b expected 4/0", c, e); end
    endtask

    task automatic test_priority();
        int t, td;
        logic [4:0] c;
        logic e;
        logic [9:0] ea [3];
        int         ec [3];
        ea = '{10'h018, 10'h01A, 10'h01B};
        ec = '{3, 5, 6};
        do_req(1'b0, 6'd1, 4'b1001, 3'd4, 8'h07, t, td, c, e);
        checks++; if (wl_addr.size() != 1 || wl_addr[0] !== 10'h019 || wl_data[0] !== 9'h107 || wl_cyc[0] != t + 3) begin errors++; $display("FAIL pri_long_write: got %0d writes expected one 019<=107 at T+3", wl_addr.size()); end
        checks++; if (td != t + 4 || c !== 5'd1 || e !== 1'b0) begin errors++; $display("FAIL pri_long_done: got T+%0d cnt %0d err %b expected T+4 1 0", td - t, c, e); end
        do_req(1'b0, 6'd1, 4'b1010, 3'd2, 8'h09, t, td, c, e);
        checks++; if (wl_addr.size() != 3) begin errors++; $display("FAIL pri_short_count: got %0d expected 3", wl_addr.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k >= wl_addr.size()) begin
                errors++; $display("FAIL pri_short_write%0d: missing expected addr %0h", k, ea[k]);
            end else if (wl_addr[k] !== ea[k] || wl_data[k] !== 9'h109 || wl_cyc[k] != t + ec[k]) begin
                errors++; $display("FAIL pri_short_write%0d: got addr %0h data %0h T+%0d expected %0h 109 T+%0d", k, wl_addr[k], wl_data[k], wl_cyc[k] - t, ea[k], ec[k]);
            end
        end
        checks++; if (td != t + 7 || c !== 5'd3 || e !== 1'b0) begin errors++; $display("FAIL pri_short_done: got T+%0d cnt %0d err %b expected T+7 3 0", td - t, c, e); end
        checks++; if (ram[5'h19] !== 9'h107) begin errors++; $display("FAIL pri_keep_long: got %0h expected 107", ram[5'h19]); end
    endtask

    task automatic test_delete();
        int t, td;
        logic [4:0] c;
        logic e;
        logic [9:0] ea [3];
        ea = '{10'h018, 10'h01A, 10'h01B};
        do_req(1'b1, 6'd1, 4'b1010, 3'd2, 8'h00, t, td, c, e);
        checks++; if (wl_addr.size() != 3) begin errors++; $display("FAIL del_count: got %0d expected 3", wl_addr.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k >= wl_addr.size()) begin
                errors++; $display("FAIL del_write%0d: missing expected addr %0h", k, ea[k]);
            end else if (wl_addr[k] !== ea[k] || wl_data[k] !== 9'h000) begin
                errors++; $display("FAIL del_write%0d: got addr %0h data %0h expected %0h 000", k, wl_addr[k], wl_data[k], ea[k]);
            end
        end
        checks++; if (td != t + 7 || c !== 5'd3 || e !== 1'b0) begin errors++; $display("FAIL del_done: got T+%0d cnt %0d err %b expected T+7 3 0", td - t, c, e); end
        checks++; if (ram[5'h19] !== 9'h107 || ram[5'h18] !== 9'h000) begin errors++; $display("FAIL del_ram: got 19=%0h 18=%0h expected 107 000", ram[5'h19], ram[5'h18]); end
    endtask

    task automatic test_errors();
        int t, td;
        logic [4:0] c;
        logic e;
        logic       ops [3];
        logic [5:0] ids [3];
        logic [2:0] lns [3];
        logic [7:0] nhs [3];
        ops = '{1'b0, 1'b0, 1'b0};
        ids = '{6'd1, 6'd1, 6'd2};
        lns = '{3'd5, 3'd2, 3'd4};
        nhs = '{8'h01, 8'h00, 8'h01};
        for (int i = 0; i < 3; i++) begin
            do_req(ops[i], ids[i], 4'b0000, lns[i], nhs[i], t, td, c, e);
            checks++;
            if (td != t + 2 || e !== 1'b1 || c !== 5'd0 || wl_addr.size() != 0) begin
                errors++; $display("FAIL err_case%0d: got T+%0d err %b cnt %0d writes %0d expected T+2 1 0 0", i, td - t, e, c, wl_addr.size());
            end
        end
        // Delete of an absent prefix is legal and writes nothing
        do_req(1'b1, 6'd1, 4'b0000, 3'd4, 8'h00, t, td, c, e);
        checks++;
        if (td != t + 4 || e !== 1'b0 || c !== 5'd0 || wl_addr.size() != 0) begin
            errors++; $display("FAIL del_absent: got T+%0d err %b cnt %0d writes %0d expected T+4 0 0 0", td - t, e, c, wl_addr.size());
        end
    endtask

    task automatic test_full_block();
        int t, td;
        int bad;
        logic [4:0] c;
        logic e;
        do_req(1'b0, 6'd0, 4'b0110, 3'd0, 8'h22, t, td, c, e);
        bad = 0;
        for (int k = 0; k < wl_addr.size(); k++) if (wl_addr[k] !== 10'(k) || wl_data[k] !== 9'h122 || wl_cyc[k] != t + 3 + k) bad++;
        checks++; if (wl_addr.size() != 16 || bad != 0) begin errors++; $display("FAIL full_writes: got %0d writes %0d bad expected 16 0", wl_addr.size(), bad); end
        checks++; if (td != t + 19 || c !== 5'd16 || e !== 1'b0) begin errors++; $display("FAIL full_done: got T+%0d cnt %0d err %b expected T+19 16 0", td - t, c, e); end
    endtask

    task automatic test_reset_mid();
        int guard;
        int dn0;
        int bad;
        guard = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        clear_log();
        dn0 = done_seen;
        req_op = 1'b0; req_ram_index = 6'd0; req_stride = 4'b0000; req_len = 3'd0; req_nexthop = 8'h33;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        while (wl_addr.size() < 5 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        checks++; if (wl_addr.size() != 5) begin errors++; $display("FAIL mid_five_writes: got %0d expected 5", wl_addr.size()); end
        #2 rst = 1'b1;
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL mid_wr_en_drop: got %b expected 0", wr_en); end
        checks++; if (init_busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_state: got busy %b ready %b expected 1 0", init_busy, req_ready); end
        @(negedge clk);
        clear_log();
        rst = 1'b0;
        guard = 0;
        while (init_busy !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bad = 0;
        for (int i = 0; i < wl_addr.size(); i++) if (wl_addr[i] !== 10'(i) || wl_data[i] !== 9'h000) bad++;
        checks++; if (wl_addr.size() != 32 || bad != 0) begin errors++; $display("FAIL mid_resweep: got %0d writes %0d bad expected 32 0", wl_addr.size(), bad); end
        checks++; if (done_seen != dn0) begin errors++; $display("FAIL mid_no_done: got %0d done pulses expected 0", done_seen - dn0); end
    endtask

    initial begin
        test_reset();
        test_insert_basic();
        test_priority();
        test_delete();
        test_errors();
        test_full_block();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage_ram_writer.md
Name: stage_ram_writer

Overview:
- Control-plane write side of one 4-bit-stride trie stage RAM. The lookup side reads 9-bit words {exist, nexthop[7:0]} at address {ram_index, stride}.
- Accepts one insert/delete request per handshake and performs controlled prefix expansion of a 0..4-bit sub-prefix over the 16-entry block.
- Enforces longest-prefix priority using an internal shadow array of stored prefix lengths.
- Emits one RAM write per cycle. After reset it sweeps the RAM to zero.

Parameters:
- NUM_ENTRY, 1024: total stage RAM words; multiple of 16.
- RAM_DATA_WIDTH, 6: block-index width; address width is RAM_DATA_WIDTH+4.

Ports:
- clk  in  1  Clock; all logic rising-edge.
- rst  in  1  Asynchronous, active-high reset.
- req_valid  in  1  Request present.
- req_ready  out  1  Block can accept a request.
- req_op  in  1  0 = insert, 1 = delete.
- req_ram_index  in  RAM_DATA_WIDTH  Target 16-entry block.
- req_stride  in  4  Stride bits; only the top req_len bits are significant.
- req_len  in  3  Prefix length within the stride, 0..4.
- req_nexthop  in  8  Next hop for insert; ignored on delete.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  RAM_DATA_WIDTH+4  RAM write address.
- wr_data  out  9  {exist, nexthop}.
- done  out  1  One-cycle completion pulse.
- done_count  out  5  Entries written by the finished request, 0..16.
- err  out  1  Qualifies done; the request was rejected.
- init_busy  out  1  Reset sweep in progress.

Behaviour:
- Reset values: init_busy = 1. All other outputs are 0. The FSM enters INIT.
- Reset is asynchronous. If asserted mid-request, wr_en drops immediately, the request is abandoned without a done pulse, and the sweep restarts after deassertion.
- States: INIT, IDLE, CHECK, EXPAND, FIN.
- INIT:
  - One write per cycle to addresses 0..NUM_ENTRY-1, wr_data = 0.
  - Shadow entries are cleared to {valid=0, len=0}.
  - After the last write, init_busy falls and the FSM enters IDLE.
- IDLE:
  - req_ready = 1 only in this state.
  - Acceptance occurs in cycle T when req_valid && req_ready; all request fields are latched. Next state is CHECK.
- CHECK (cycle T+1): the request is an error if any of the following holds:
  - req_len > 4
  - insert with req_nexthop == 0 (0 means "absent" to the lookup side)
  - req_ram_index*16 >= NUM_ENTRY
- On error: FIN with count 0. Otherwise: base = stride with the low (4-len) bits zeroed, N = 2^(4-len). Next state is EXPAND.
- EXPAND: one candidate entry e = base+k per cycle, k = 0..N-1.
  - Insert: write if shadow invalid or shadow.len <= len (equal length replaces the nexthop). wr_data = {1, nexthop}. Shadow becomes {1, len}.
  - Delete: write only if shadow valid and shadow.len == len. wr_data = 0. Shadow becomes {0, 0}.
  - Delete does not restore a covering shorter prefix; control software re-inserts it. Lookup falls back to the previous stage's nexthop.
  - Skipped entries: no strobe, shadow unchanged.
- Write timing:
  - wr_* are registered. The write for candidate k appears in cycle T+3+k.
  - Shadow reads are asynchronous.
  - Shadow updates in the same cycle as the registered write.
- FIN: done = 1 for one cycle, with done_count and err valid that cycle. err = 0 on success.
  - Success: done in cycle T+N+3, following the last candidate's write slot.
  - Error: done in cycle T+2.
  - req_ready returns the following cycle.
- No back-to-back acceptance; minimum request spacing is N+4 cycles.
- done_count increments only on issued writes. Its maximum is 16 (len 0, all written).

Decomposition:
- Shared package trie_pkg holds:
  - STRIDE_W = 4, ENTRY_W = 9, LEN_W = 3, NH_W = 8
  - OP_INSERT / OP_DELETE
  - FSM state enum
- One natural sub-module: shadow_len_ram.
  - NUM_ENTRY x 4 bits {valid, len[2:0]}, asynchronous read, synchronous write.
  - Instantiated once; addressed by the same {ram_index, stride} as the stage RAM.

Test Plan:
- Reset sweep, NUM_ENTRY=32 -> 32 writes to addr 0..31 with data 0. init_busy falls after the last write, then req_ready = 1.
- Insert idx=1, stride=4'b1010, len=2, nh=0x05 -> writes to 0x18..0x1B with data 9'h105. done_count = 4, err = 0.
- Insert idx=1, stride=4'b1001, len=4, nh=0x07 -> single write to 0x19 with data 9'h107. Then insert stride 4'b1010, len=2, nh=0x09 -> writes to 0x18, 0x1A, 0x1B only, 0x19 untouched, count 3.
- Delete idx=1, stride=4'b1010, len=2 -> data 0 to 0x18, 0x1A, 0x1B; 0x19 keeps 0x107; count 3.
- Errors: len=5; insert with nh=0; idx=2 with NUM_ENTRY=32 -> each gives done and err = 1 at T+2, count 0, no wr_en.
- Insert len=0 at idx=0; assert rst after the 5th write -> wr_en = 0 combinationally, no done pulse, INIT sweep restarts from addr 0.
